// File: rtl/cnn_loop_sequencer.sv
// cnn_loop_sequencer: walks the tiled conv loop nest row->col->to->ti->i->j, one index tuple per accepted beat.
// Ports: clk_i/reset_n_i (async active-low), start_i/busy_o/done_o parent handshake,
// valid_o/ready_i datapath handshake, row_o..j_o loop indices, in_row_o/in_col_o input coords,
// tn_mask_o/tm_mask_o partial-tile lane masks, first_o/last_o accumulator clear/write-back markers.
module cnn_loop_sequencer #(
  parameter int N_p = 4,
  parameter int M_p = 4,
  parameter int K_p = 2,
  parameter int R_p = 16,
  parameter int C_p = 16,
  parameter int S_p = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2,
  localparam int RW = R_p > 1 ? $clog2(R_p) : 1,
  localparam int CW = C_p > 1 ? $clog2(C_p) : 1,
  localparam int TOW = M_p > 1 ? $clog2(M_p) : 1,
  localparam int TIW = N_p > 1 ? $clog2(N_p) : 1,
  localparam int KW = K_p > 1 ? $clog2(K_p) : 1,
  localparam int IRW = (R_p - 1) * S_p + K_p > 1 ? $clog2((R_p - 1) * S_p + K_p) : 1,
  localparam int ICW = (C_p - 1) * S_p + K_p > 1 ? $clog2((C_p - 1) * S_p + K_p) : 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            start_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [RW-1:0]   row_o,
  output logic [CW-1:0]   col_o,
  output logic [TOW-1:0]  to_o,
  output logic [TIW-1:0]  ti_o,
  output logic [KW-1:0]   i_o,
  output logic [KW-1:0]   j_o,
  output logic [IRW-1:0]  in_row_o,
  output logic [ICW-1:0]  in_col_o,
  output logic [Tn_p-1:0] tn_mask_o,
  output logic [Tm_p-1:0] tm_mask_o,
  output logic            first_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);
  if (K_p < 1 || S_p < 1 || Tn_p < 1 || Tm_p < 1) begin : g_bad_param
    $error("cnn_loop_sequencer: K_p, S_p, Tn_p and Tm_p must all be >= 1");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic xfer, j_w, i_w, ti_w, to_w, col_w, row_w, fin;
  logic c_i, c_ti, c_to, c_col, c_row, run_nx;
  logic [RW-1:0] row_nx;
  logic [CW-1:0] col_nx;
  logic [TOW-1:0] to_nx;
  logic [TIW-1:0] ti_nx;
  logic [KW-1:0] i_nx, j_nx;
  logic [Tn_p-1:0] tn_m;
  logic [Tm_p-1:0] tm_m;
  // Carry chain: each counter advances only when every inner counter wraps on this transfer;
  // the final tuple wraps everything, which returns the indices to zero for free.
  always_comb begin
    xfer = state == RUN && ready_i;
    j_w = j_o == KW'(K_p - 1);
    i_w = i_o == KW'(K_p - 1);
    ti_w = int'(ti_o) + Tn_p >= N_p;
    to_w = int'(to_o) + Tm_p >= M_p;
    col_w = col_o == CW'(C_p - 1);
    row_w = row_o == RW'(R_p - 1);
    fin = j_w && i_w && ti_w && to_w && col_w && row_w;
    c_i = xfer && j_w;
    c_ti = c_i && i_w;
    c_to = c_ti && ti_w;
    c_col = c_to && to_w;
    c_row = c_col && col_w;
    j_nx = !xfer ? j_o : j_w ? '0 : j_o + 1'b1;
    i_nx = !c_i ? i_o : i_w ? '0 : i_o + 1'b1;
    ti_nx = !c_ti ? ti_o : ti_w ? '0 : ti_o + TIW'(Tn_p);
    to_nx = !c_to ? to_o : to_w ? '0 : to_o + TOW'(Tm_p);
    col_nx = !c_col ? col_o : col_w ? '0 : col_o + 1'b1;
    row_nx = !c_row ? row_o : row_w ? '0 : row_o + 1'b1;
  end
  always_comb begin
    state_nx = state == IDLE ? (start_i ? RUN : IDLE) :
               state == RUN  ? (xfer && fin ? DONE : RUN) : IDLE;
    run_nx = state_nx == RUN;
  end
  always_comb begin
    valid_o = state == RUN;
    busy_o = state == RUN;
    done_o = state == DONE;
  end
  // Masks are computed from the next tuple so they register in the same edge as the indices.
  always_comb begin
    tn_m = '0;
    tm_m = '0;
    for (int k = 0; k < Tn_p; k++) tn_m[k] = int'(ti_nx) + k < N_p;
    for (int k = 0; k < Tm_p; k++) tm_m[k] = int'(to_nx) + k < M_p;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      {row_o, col_o, to_o, ti_o, i_o, j_o} <= '0;
      {in_row_o, in_col_o, tn_mask_o, tm_mask_o, first_o, last_o} <= '0;
    end else begin
      {row_o, col_o, to_o, ti_o, i_o, j_o} <= {row_nx, col_nx, to_nx, ti_nx, i_nx, j_nx};
      in_row_o <= run_nx ? IRW'(row_nx) * IRW'(S_p) + IRW'(i_nx) : '0;
      in_col_o <= run_nx ? ICW'(col_nx) * ICW'(S_p) + ICW'(j_nx) : '0;
      tn_mask_o <= run_nx ? tn_m : '0;
      tm_mask_o <= run_nx ? tm_m : '0;
      first_o <= run_nx && ti_nx == '0 && i_nx == '0 && j_nx == '0;
      last_o <= run_nx && int'(ti_nx) + Tn_p >= N_p && i_nx == KW'(K_p - 1) && j_nx == KW'(K_p - 1);
    end
  end
endmodule

// File: tb/tb_cnn_loop_sequencer.sv
// tb_cnn_loop_sequencer: randomized self-checking bench for cnn_loop_sequencer against a nested-loop model.
module tb_cnn_loop_sequencer;
  typedef struct packed {
    int row; int col; int to; int ti; int i; int j;
    int irow; int icol; int tnm; int tmm; int first; int last;
  } view_t;
  localparam int CR[3] = '{16, 2, 16};
  localparam int CC[3] = '{16, 2, 16};
  localparam int CN[3] = '{4, 3, 4};
  localparam int CM[3] = '{4, 4, 4};
  localparam int CK[3] = '{2, 2, 3};
  localparam int CS[3] = '{1, 1, 2};
  localparam int CTN[3] = '{2, 2, 2};
  localparam int CTM[3] = '{2, 2, 2};
  logic clk = 1'b0, rst_n = 1'b0;
  logic start [3];
  logic ready [3];
  int total = 0, passed = 0, last_nf = 0, last_nl = 0;
  view_t exp_q[$];
  logic [3:0] a_row, a_col; logic [1:0] a_to, a_ti; logic [0:0] a_i, a_j;
  logic [4:0] a_ir, a_ic; logic [1:0] a_tn, a_tm; logic a_first, a_last, a_valid, a_busy, a_done;
  logic [0:0] b_row, b_col; logic [1:0] b_to, b_ti; logic [0:0] b_i, b_j;
  logic [1:0] b_ir, b_ic; logic [1:0] b_tn, b_tm; logic b_first, b_last, b_valid, b_busy, b_done;
  logic [3:0] c_row, c_col; logic [1:0] c_to, c_ti; logic [1:0] c_i, c_j;
  logic [5:0] c_ir, c_ic; logic [1:0] c_tn, c_tm; logic c_first, c_last, c_valid, c_busy, c_done;
  always #5 clk = ~clk;
  cnn_loop_sequencer dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[0]), .ready_i(ready[0]), .valid_o(a_valid),
    .row_o(a_row), .col_o(a_col), .to_o(a_to), .ti_o(a_ti), .i_o(a_i), .j_o(a_j),
    .in_row_o(a_ir), .in_col_o(a_ic), .tn_mask_o(a_tn), .tm_mask_o(a_tm),
    .first_o(a_first), .last_o(a_last), .busy_o(a_busy), .done_o(a_done));
  cnn_loop_sequencer #(.N_p(3), .M_p(4), .K_p(2), .R_p(2), .C_p(2), .S_p(1), .Tn_p(2), .Tm_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[1]), .ready_i(ready[1]), .valid_o(b_valid),
    .row_o(b_row), .col_o(b_col), .to_o(b_to), .ti_o(b_ti), .i_o(b_i), .j_o(b_j),
    .in_row_o(b_ir), .in_col_o(b_ic), .tn_mask_o(b_tn), .tm_mask_o(b_tm),
    .first_o(b_first), .last_o(b_last), .busy_o(b_busy), .done_o(b_done));
  cnn_loop_sequencer #(.K_p(3), .S_p(2)) dut_c (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[2]), .ready_i(ready[2]), .valid_o(c_valid),
    .row_o(c_row), .col_o(c_col), .to_o(c_to), .ti_o(c_ti), .i_o(c_i), .j_o(c_j),
    .in_row_o(c_ir), .in_col_o(c_ic), .tn_mask_o(c_tn), .tm_mask_o(c_tm),
    .first_o(c_first), .last_o(c_last), .busy_o(c_busy), .done_o(c_done));
  function automatic view_t got(input int sel);
    case (sel)
      0: return view_t'{int'(a_row), int'(a_col), int'(a_to), int'(a_ti), int'(a_i), int'(a_j),
                        int'(a_ir), int'(a_ic), int'(a_tn), int'(a_tm), int'(a_first), int'(a_last)};
      1: return view_t'{int'(b_row), int'(b_col), int'(b_to), int'(b_ti), int'(b_i), int'(b_j),
                        int'(b_ir), int'(b_ic), int'(b_tn), int'(b_tm), int'(b_first), int'(b_last)};
      default: return view_t'{int'(c_row), int'(c_col), int'(c_to), int'(c_ti), int'(c_i), int'(c_j),
                        int'(c_ir), int'(c_ic), int'(c_tn), int'(c_tm), int'(c_first), int'(c_last)};
    endcase
  endfunction
  function automatic logic [2:0] flags(input int sel);
    return sel == 0 ? {a_valid, a_busy, a_done} : sel == 1 ? {b_valid, b_busy, b_done} : {c_valid, c_busy, c_done};
  endfunction
  function automatic view_t mk(input int sel, input int row, input int col, input int to, input int ti,
                               input int i, input int j);
    view_t v;
    int last_ti = ((CN[sel] + CTN[sel] - 1) / CTN[sel] - 1) * CTN[sel];
    v = '{row: row, col: col, to: to, ti: ti, i: i, j: j, default: 0};
    v.irow = row * CS[sel] + i;
    v.icol = col * CS[sel] + j;
    for (int k = 0; k < CTN[sel]; k++) if (ti + k < CN[sel]) v.tnm += 1 << k;
    for (int k = 0; k < CTM[sel]; k++) if (to + k < CM[sel]) v.tmm += 1 << k;
    v.first = int'(ti == 0 && i == 0 && j == 0);
    v.last = int'(ti == last_ti && i == CK[sel] - 1 && j == CK[sel] - 1);
    return v;
  endfunction
  task automatic build_exp(input int sel);
    exp_q.delete();
    for (int row = 0; row < CR[sel]; row++)
      for (int col = 0; col < CC[sel]; col++)
        for (int to = 0; to < CM[sel]; to += CTM[sel])
          for (int ti = 0; ti < CN[sel]; ti += CTN[sel])
            for (int i = 0; i < CK[sel]; i++)
              for (int j = 0; j < CK[sel]; j++) exp_q.push_back(mk(sel, row, col, to, ti, i, j));
  endtask
  task automatic do_reset();
    for (int s = 0; s < 3; s++) begin start[s] = 1'b0; ready[s] = 1'b0; end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic run_pass(input int sel, input bit rnd, input bit hold, input int stop_at);
    int n = 0, cyc = 0, nf = 0, nl = 0;
    bit stall = 0;
    view_t g, snap;
    build_exp(sel);
    start[sel] = 1'b1;
    @(negedge clk);
    if (!hold) start[sel] = 1'b0;
    while (n < stop_at && cyc < 30000) begin
      g = got(sel);
      total++;
      if (g !== exp_q[n] || flags(sel) !== 3'b110)
        $display("FAIL tuple sel%0d beat %0d: got %p flags(v,b,d)=%b, expected %p flags 110", sel, n, g, flags(sel), exp_q[n]);
      else passed++;
      if (stall) begin
        total++;
        if (g !== snap) $display("FAIL stall_hold sel%0d beat %0d: got %p, expected held %p", sel, n, g, snap);
        else passed++;
      end
      nf += g.first;
      nl += g.last;
      ready[sel] = rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1;
      snap = g;
      stall = !ready[sel];
      @(negedge clk);
      cyc++;
      if (ready[sel]) n++;
    end
    total++;
    if (cyc >= 30000) $display("FAIL pass_timeout sel%0d: got %0d beats, expected %0d", sel, n, stop_at);
    else passed++;
    last_nf = nf;
    last_nl = nl;
  endtask
  task automatic check_done(input int sel, input bit hold);
    view_t g = got(sel);
    total++;
    if (flags(sel) !== 3'b001 || {g.row, g.col, g.to, g.ti, g.i, g.j} != '0)
      $display("FAIL done_pulse sel%0d: got flags(v,b,d)=%b idx %p, expected flags 001 and zero indices", sel, flags(sel), g);
    else passed++;
    @(negedge clk);
    total++;
    if (flags(sel) !== 3'b000) $display("FAIL idle_after_done sel%0d: got flags %b, expected 000", sel, flags(sel));
    else passed++;
    @(negedge clk);
    g = got(sel);
    total++;
    if (flags(sel)[2] !== logic'(hold) || (hold && g !== exp_q[0]))
      $display("FAIL restart sel%0d: got valid %b tuple %p, expected valid %b", sel, flags(sel)[2], g, hold);
    else passed++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (got(s) !== view_t'(0) || flags(s) !== 3'b000)
        $display("FAIL reset_state sel%0d: got %p flags %b, expected all zero", s, got(s), flags(s));
      else passed++;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (flags(0) !== 3'b000) $display("FAIL idle_no_start: got flags %b, expected 000", flags(0));
    else passed++;
  endtask
  task automatic test_full_pass();
    run_pass(0, 1'b0, 1'b0, 4096);
    check_done(0, 1'b0);
    do_reset();
  endtask
  task automatic test_random_ready();
    run_pass(0, 1'b1, 1'b0, 4096);
    check_done(0, 1'b0);
    do_reset();
  endtask
  task automatic test_small_config();
    run_pass(1, 1'b0, 1'b0, 64);
    total++;
    if (last_nf != 8 || last_nl != 8) $display("FAIL first_last_count: got %0d/%0d, expected 8/8", last_nf, last_nl);
    else passed++;
    check_done(1, 1'b0);
    do_reset();
  endtask
  task automatic test_stride();
    run_pass(2, 1'b0, 1'b0, 655);
    total++;
    if (c_row !== 4'd1 || c_col !== 4'd2 || c_i !== 2'd2 || c_j !== 2'd1 || c_ir !== 6'd4 || c_ic !== 6'd5)
      $display("FAIL stride_coords: got row %0d col %0d i %0d j %0d in_row %0d in_col %0d, expected 1 2 2 1 4 5",
               c_row, c_col, c_i, c_j, c_ir, c_ic);
    else passed++;
    do_reset();
  endtask
  task automatic test_reset_mid();
    bit bad = 0;
    run_pass(0, 1'b0, 1'b0, 100);
    ready[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (got(0) !== view_t'(0) || flags(0) !== 3'b000)
      $display("FAIL async_reset: got %p flags %b, expected all zero before next edge", got(0), flags(0));
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (flags(0) !== 3'b000) bad = 1;
    end
    total++;
    if (bad) $display("FAIL reset_idle: got activity after mid-pass reset, expected flags 000");
    else passed++;
    run_pass(0, 1'b0, 1'b0, 20);
    do_reset();
  endtask
  task automatic test_back_to_back();
    run_pass(0, 1'b0, 1'b1, 4096);
    check_done(0, 1'b1);
    do_reset();
  endtask
  initial begin
    for (int s = 0; s < 3; s++) begin start[s] = 1'b0; ready[s] = 1'b0; end
    test_reset();
    test_full_pass();
    test_random_ready();
    test_small_config();
    test_stride();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
